// File: rtl/shift194_seq_if.sv
// rtl/shift194_seq_if.sv - command/status bundle between a host and the 74194 sequencer.
interface shift194_seq_if;
    logic       start;
    logic [2:0] op;
    logic [3:0] data;
    logic [2:0] cnt;
    logic       ser_in;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] result;

    modport master (
        output start, op, data, cnt, ser_in,
        input  busy, done, err, result
    );

    modport slave (
        input  start, op, data, cnt, ser_in,
        output busy, done, err, result
    );
endinterface

// File: rtl/shift194_seq.sv
// rtl/shift194_seq.sv - command sequencer driving an external 74194 4-bit shift register.
// Define SHIFT194_SEQ_ROTATE_EN to make ROTL/ROTR legal commands.
module shift194_seq (
    input  logic            clk,
    input  logic            rst,
    shift194_seq_if.slave   cmd,
    input  logic            QA,
    input  logic            QB,
    input  logic            QC,
    input  logic            QD,
    output logic            S1,
    output logic            S0,
    output logic            A,
    output logic            B,
    output logic            C,
    output logic            D,
    output logic            SL,
    output logic            SR,
    output logic            CR
);
    typedef enum logic [2:0] {IDLE, CLR, LOAD, SHIFT, CAPT} state_t;

    localparam logic [2:0] OP_CLEAR = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
`ifdef SHIFT194_SEQ_ROTATE_EN
    localparam logic [2:0] OP_ROTL  = 3'b100;
    localparam logic [2:0] OP_ROTR  = 3'b101;
`endif

    state_t     state, state_nx;
    logic [2:0] op_q;
    logic [2:0] cnt_q;
    logic [3:0] data_q;
    logic       ser_q;
    logic [3:0] result_q;
    logic       done_q, done_nx;
    logic       err_q, err_nx;
    logic       accept;
    logic       op_legal;
    logic       cr_fsm;
    logic [1:0] mode;

`ifdef SHIFT194_SEQ_ROTATE_EN
    assign op_legal = (cmd.op <= 3'd5);
`else
    assign op_legal = (cmd.op <= 3'd3);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 3'b000;
            cnt_q    <= 3'b000;
            data_q   <= 4'b0000;
            ser_q    <= 1'b0;
            result_q <= 4'b0000;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= done_nx;
            err_q  <= err_nx;
            if (accept) begin
                op_q   <= cmd.op;
                cnt_q  <= cmd.cnt;
                data_q <= cmd.data;
                ser_q  <= cmd.ser_in;
            end else if (state == SHIFT && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (state == CAPT) begin
                result_q <= {QA, QB, QC, QD};
            end
        end
    end

    always_comb begin
        state_nx     = state;
        done_nx      = 1'b0;
        err_nx       = 1'b0;
        accept       = 1'b0;
        cr_fsm       = 1'b1;
        mode         = 2'b00;
        {A, B, C, D} = 4'b0000;
        SL           = 1'b0;
        SR           = 1'b0;
        case (state)
            IDLE: begin
                if (cmd.start) begin
                    if (op_legal) begin
                        accept = 1'b1;
                        if (cmd.op == OP_CLEAR)     state_nx = CLR;
                        else if (cmd.op == OP_LOAD) state_nx = LOAD;
                        else                        state_nx = SHIFT;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            CLR: begin
                cr_fsm   = 1'b0;
                state_nx = CAPT;
            end
            LOAD: begin
                mode         = 2'b11;
                {A, B, C, D} = data_q;
                state_nx     = CAPT;
            end
            SHIFT: begin
                // cnt_q == 0 on entry means a single hold cycle
                if (cnt_q != 3'd0) begin
                    case (op_q)
                        OP_SHL: begin mode = 2'b10; SL = ser_q; end
                        OP_SHR: begin mode = 2'b01; SR = ser_q; end
`ifdef SHIFT194_SEQ_ROTATE_EN
                        OP_ROTL: begin mode = 2'b10; SL = QA; end
                        OP_ROTR: begin mode = 2'b01; SR = QD; end
`endif
                        default: ;
                    endcase
                end
                if (cnt_q <= 3'd1) state_nx = CAPT;
            end
            CAPT: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign {S1, S0}   = mode;
    assign CR         = cr_fsm & ~rst;
    assign cmd.busy   = (state != IDLE);
    assign cmd.done   = done_q;
    assign cmd.err    = err_q;
    assign cmd.result = result_q;
endmodule

// File: tb/tb_shift194_seq.sv
// tb/tb_shift194_seq.sv - scoreboard bench for shift194_seq with a behavioural 74194 in the loop.
module tb_shift194_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic QA, QB, QC, QD;
    logic S1, S0, A, B, C, D, SL, SR, CR;
    logic [3:0] q;

    shift194_seq_if cmd_if();

    shift194_seq dut (
        .clk (clk), .rst (rst), .cmd (cmd_if),
        .QA (QA), .QB (QB), .QC (QC), .QD (QD),
        .S1 (S1), .S0 (S0), .A (A), .B (B), .C (C), .D (D),
        .SL (SL), .SR (SR), .CR (CR)
    );

    always #5 clk = ~clk;

    // 74194: shift-left moves toward QA with SL entering QD; shift-right moves toward QD with SR entering QA
    assign {QA, QB, QC, QD} = q;
    always @(posedge clk or negedge CR) begin
        if (!CR) q <= 4'b0000;
        else begin
            case ({S1, S0})
                2'b01:   q <= {SR, q[3:1]};
                2'b10:   q <= {q[2:0], SL};
                2'b11:   q <= {A, B, C, D};
                default: ;
            endcase
        end
    end

    typedef struct {
        bit         is_err;
        logic [3:0] res;
        logic [1:0] mode;
        int         mode_n;
        int         busy_n;
        int         cr_n;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts register-control activity per command, compares on each done/err
    int busy_n = 0, mode_n = 0, cr_n = 0;
    logic [1:0] last_mode = 2'b00;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_n = 0; mode_n = 0; cr_n = 0; last_mode = 2'b00;
        end else begin
            if (cmd_if.busy) busy_n++;
            if ({S1, S0} != 2'b00) begin mode_n++; last_mode = {S1, S0}; end
            if (!CR) cr_n++;
            if (cmd_if.done || cmd_if.err) begin
                if (exp_q.size() == 0) begin
                    check("spurious_event", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("kind_err",  int'(cmd_if.err), int'(e.is_err));
                    check("kind_done", int'(cmd_if.done), int'(!e.is_err));
                    check("result",    int'(cmd_if.result), int'(e.res));
                    check("mode",      int'(last_mode), int'(e.mode));
                    check("mode_cycles", mode_n, e.mode_n);
                    check("busy_cycles", busy_n, e.busy_n);
                    check("cr_cycles",   cr_n, e.cr_n);
                end
                busy_n = 0; mode_n = 0; cr_n = 0; last_mode = 2'b00;
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [3:0] d, input logic [2:0] c,
                         input logic s, input bit push, input bit is_err, input logic [3:0] res,
                         input logic [1:0] mode, input int m_n, input int b_n, input int c_n);
        exp_t e;
        @(posedge clk); #1;
        cmd_if.start = 1'b1; cmd_if.op = o; cmd_if.data = d; cmd_if.cnt = c; cmd_if.ser_in = s;
        if (push) begin
            e.is_err = is_err; e.res = res; e.mode = mode;
            e.mode_n = m_n; e.busy_n = b_n; e.cr_n = c_n;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_if.start = 1'b0;
    endtask

    task automatic wait_event;
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_if.done || cmd_if.err) begin seen = 1; break; end
        end
        if (!seen) check("timeout", 0, 1);
    endtask

    task automatic run(input logic [2:0] o, input logic [3:0] d, input logic [2:0] c,
                       input logic s, input bit is_err, input logic [3:0] res,
                       input logic [1:0] mode, input int m_n, input int b_n, input int c_n);
        issue(o, d, c, s, 1'b1, is_err, res, mode, m_n, b_n, c_n);
        wait_event();
    endtask

    task automatic check_reset_state;
        check("rst_busy",   int'(cmd_if.busy), 0);
        check("rst_done",   int'(cmd_if.done), 0);
        check("rst_err",    int'(cmd_if.err), 0);
        check("rst_result", int'(cmd_if.result), 0);
        check("rst_mode",   int'({S1, S0}), 0);
        check("rst_cr",     int'(CR), 0);
    endtask

    initial begin
        cmd_if.start = 1'b0; cmd_if.op = 3'b000; cmd_if.data = 4'b0000;
        cmd_if.cnt = 3'd0; cmd_if.ser_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_state();
        rst = 1'b0;
        #1 check("cr_after_release", int'(CR), 1);

        run(3'b001, 4'b1011, 3'd0, 1'b0, 0, 4'b1011, 2'b11, 1, 2, 0);
        run(3'b001, 4'b1000, 3'd0, 1'b0, 0, 4'b1000, 2'b11, 1, 2, 0);
        run(3'b011, 4'b0000, 3'd3, 1'b1, 0, 4'b1111, 2'b01, 3, 4, 0);
        run(3'b001, 4'b1000, 3'd0, 1'b0, 0, 4'b1000, 2'b11, 1, 2, 0);
`ifdef SHIFT194_SEQ_ROTATE_EN
        // rotate left by 5 on 4 bits equals rotate by 1: 1000 -> 0001
        run(3'b100, 4'b0000, 3'd5, 1'b0, 0, 4'b0001, 2'b10, 5, 6, 0);
`else
        run(3'b100, 4'b0000, 3'd5, 1'b0, 1, 4'b1000, 2'b00, 0, 0, 0);
`endif
        run(3'b001, 4'b1000, 3'd0, 1'b0, 0, 4'b1000, 2'b11, 1, 2, 0);
        run(3'b010, 4'b0000, 3'd0, 1'b1, 0, 4'b1000, 2'b00, 0, 2, 0);
        run(3'b001, 4'b1001, 3'd0, 1'b0, 0, 4'b1001, 2'b11, 1, 2, 0);
        run(3'b010, 4'b0000, 3'd2, 1'b0, 0, 4'b0100, 2'b10, 2, 3, 0);
        run(3'b000, 4'b1111, 3'd0, 1'b0, 0, 4'b0000, 2'b00, 0, 2, 1);
        run(3'b001, 4'b0110, 3'd0, 1'b0, 0, 4'b0110, 2'b11, 1, 2, 0);

        // starts held through the whole SHR must not spawn a second command
        issue(3'b011, 4'b0000, 3'd3, 1'b1, 1'b1, 0, 4'b1110, 2'b01, 3, 4, 0);
        cmd_if.start = 1'b1; cmd_if.op = 3'b001; cmd_if.data = 4'b1111;
        repeat (3) @(posedge clk);
        #1 cmd_if.start = 1'b0;
        wait_event();

        run(3'b110, 4'b0000, 3'd0, 1'b0, 1, 4'b1110, 2'b00, 0, 0, 0);
        run(3'b111, 4'b0000, 3'd0, 1'b0, 1, 4'b1110, 2'b00, 0, 0, 0);

        // abort a long shift with reset
        issue(3'b010, 4'b0000, 3'd7, 1'b1, 1'b0, 0, 4'b0000, 2'b00, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 check("mid_shift_busy", int'(cmd_if.busy), 1);
        rst = 1'b1;
        #1 check_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post_abort_busy",   int'(cmd_if.busy), 0);
        check("post_abort_result", int'(cmd_if.result), 0);

        run(3'b001, 4'b0101, 3'd0, 1'b0, 0, 4'b0101, 2'b11, 1, 2, 0);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
